fb_video_scanout: RTL

Monochrome video scanout engine for the Sun-2 framebuffer. It is the reader on the read-only port of the 128 KB dual-port framebuffer RAM, while the CPU writes through the other port. It runs raster counters, fetches one 16-bit word per 16 pixels, and serializes the words MSB-first into a 1-bit pixel stream. Sync, blank and the vertical-retrace interrupt pulse are pipeline-aligned with that stream.

---
 rtl/fb_video_scanout.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fb_video_scanout.sv
// fb_video_scanout
//   Monochrome raster scanout engine. Runs horizontal/vertical counters,
//   fetches one 16-bit framebuffer word per 16 pixels from the read port of
//   the dual-port framebuffer RAM, and shifts each word out MSB-first as a
//   1-bit pixel stream. Blank, syncs and the frame interrupt are delayed so
//   they line up with the pixel they describe.
//
// Ports
//   clk        pixel clock, one pixel per cycle
//   reset_n    asynchronous active-low reset
//   video_en   0 forces pix low; timing and fetches keep running
//   fb_addr    word address to the RAM read port
//   fb_en      read strobe to the RAM read port
//   fb_data    RAM read data, valid the cycle after fb_en
//   pix        serialized pixel
//   blank      1 outside the visible area
//   hsync_n    horizontal sync, active low
//   vsync_n    vertical sync, active low
//   frame_irq  one-cycle pulse at start of vertical blank
module fb_video_scanout #(
    parameter int          H_ACTIVE = 1152,
    parameter int          H_FP     = 40,
    parameter int          H_SYNC   = 128,
    parameter int          H_BP     = 208,
    parameter int          V_ACTIVE = 900,
    parameter int          V_FP     = 2,
    parameter int          V_SYNC   = 4,
    parameter int          V_BP     = 31,
    parameter logic [16:0] FB_BASE  = 17'h0,
    parameter bit          INVERT   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_en,
    output logic [16:0] fb_addr,
    output logic        fb_en,
    input  logic [15:0] fb_data,
    output logic        pix,
    output logic        blank,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so window end points equal to the total still fit.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt, h_nxt;
    logic [VW-1:0] vcnt, v_nxt;
    logic          started;
    logic [16:0]   ptr, ptr_src;
    logic          fetch_nxt, frame_end;
    logic          active_c, hs_c, vs_c, irq_c;
    logic          blank_d1, hsync_d1, vsync_d1, irq_d1;
    logic          fetch_d;
    logic [15:0]   shifter;
    logic          pix_bit;

    // The counters hold at (0,0) for the first edge after reset so that the
    // registered fetch strobe for pixel (0,0) is issued on that edge and is
    // then high in the same cycle the counters sit at (0,0).
    always_comb begin
        h_nxt = hcnt;
        v_nxt = vcnt;
        if (started) begin
            if (hcnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                h_nxt = hcnt + 1'b1;
            end
        end
    end

    // Fetch decision is made one cycle ahead from the next counter value,
    // which keeps fb_en registered yet aligned with hcnt[3:0]==0.
    assign fetch_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT) && (h_nxt[3:0] == 4'd0);
    assign frame_end = started && (hcnt == H_LAST) && (vcnt == V_LAST);
    assign ptr_src   = frame_end ? FB_BASE : ptr;

    assign active_c = started && (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_c     = started && (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_c     = started && (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign irq_c    = started && (hcnt == '0) && (vcnt == V_ACT);

    // The word arriving from the RAM goes straight to the pixel register on
    // its load cycle; the shifter keeps only the 15 bits still to come.
    assign pix_bit = fetch_d ? fb_data[15] : shifter[15];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            ptr     <= FB_BASE;
            fb_en   <= 1'b0;
            fb_addr <= FB_BASE;
        end else begin
            started <= 1'b1;
            hcnt    <= h_nxt;
            vcnt    <= v_nxt;
            fb_en   <= fetch_nxt;
            if (fetch_nxt) begin
                fb_addr <= ptr_src;
                ptr     <= ptr_src + 17'd1;
            end else if (frame_end) begin
                ptr     <= FB_BASE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_d1  <= 1'b1;
            hsync_d1  <= 1'b1;
            vsync_d1  <= 1'b1;
            irq_d1    <= 1'b0;
            blank     <= 1'b1;
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
            frame_irq <= 1'b0;
        end else begin
            blank_d1  <= ~active_c;
            hsync_d1  <= ~hs_c;
            vsync_d1  <= ~vs_c;
            irq_d1    <= irq_c;
            blank     <= blank_d1;
            hsync_n   <= hsync_d1;
            vsync_n   <= vsync_d1;
            frame_irq <= irq_d1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_d <= 1'b0;
            shifter <= '0;
            pix     <= 1'b0;
        end else begin
            fetch_d <= fb_en;
            shifter <= fetch_d ? {fb_data[14:0], 1'b0} : {shifter[14:0], 1'b0};
            // blank_d1 is the blank of the pixel being registered here.
            pix     <= (pix_bit ^ INVERT) & video_en & ~blank_d1;
        end
    end

endmodule
